seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, registered ALU with a start/busy/done handshake, status flags and an iterative unsigned multiplier. Operands and opcode are latched on an accepted start. Single-cycle operations complete in one clock. MUL runs a shift-add state machine for WIDTH clocks. It serves as the arithmetic core for the trainer's sequential exercises and drives result/flag LEDs directly.

## Interface
- WIDTH, 4, operand/result width in bits; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, latched on accepted start.
- b  input  WIDTH  operand B, latched on accepted start.
- operation  input  3  opcode, latched on accepted start.
- result  output  WIDTH  result, or low half of the product for MUL.
- result_hi  output  WIDTH  high half of the product for MUL; 0 for all other ops.
- carry  output  1  carry out (ADD), borrow (SUB), shifted-out bit (SHL), |result_hi (MUL); 0 otherwise.
- overflow  output  1  two's-complement overflow for ADD/SUB; 0 otherwise.
- zero  output  1  full registered result is all zeros (includes result_hi for MUL).
- negative  output  1  result[WIDTH-1].
- busy  output  1  multiply in progress.
- done  output  1  one-cycle completion pulse.

## Operation
- Reset: state IDLE; result, result_hi, carry, overflow, zero, negative, busy and done are all 0.
- Opcodes:
  - 000 AND.
  - 001 OR.
  - 010 ADD: a+b mod 2^WIDTH.
  - 011 SUB: a-b mod 2^WIDTH; carry=1 iff a<b unsigned.
  - 100 XOR.
  - 101 SHL: a<<1; carry=a[WIDTH-1]; b is ignored.
  - 110 SLTU: result=1 if a<b unsigned, else 0.
  - 111 MUL: unsigned, 2*WIDTH-bit product split across {result_hi, result}.
- Overflow:
  - ADD: operand sign bits equal and result sign differs.
  - SUB: operand sign bits differ and result sign differs from a.
- States:
  - IDLE: start=1 latches a, b and operation.
    - Non-MUL op: the result and all flags are written on the same edge; done=1 next cycle; stay in IDLE.
    - MUL: clear the accumulator, go to MULT, busy=1.
  - MULT: one multiplier bit per edge (LSB first): add the shifted multiplicand when the bit is 1.
    - A counter runs 0..WIDTH-1.
    - On the edge where the counter reaches WIDTH-1: write the product and flags, busy=0, done=1, return to IDLE.
- result, result_hi and the flags hold their last completed values until the next completion.
- They do not change while MULT is running.
- start while busy=1 is ignored and is not queued.
- Changes on a, b or operation after acceptance have no effect.
- start asserted in the cycle where done=1 is accepted, so back-to-back operations are allowed.
- rst at any time, including mid-MULT: abort and return to reset values on that edge; no done pulse.

## Timing
- Accept edge N = first rising edge with start=1 in IDLE.
- Non-MUL ops: result and flags valid, and done=1, in the cycle after edge N (latency 1); busy stays 0.
- MUL:
  - busy=1 after edges N through N+WIDTH-1.
  - Product and flags are written at edge N+WIDTH, where busy falls and done rises (latency WIDTH+1).
  - At WIDTH=4, done appears after edge N+4.
- done is high for exactly one cycle per accepted operation.
- With start held high, the next operation is accepted at the edge that ends the done cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, WIDTH=4: assert rst for 2 cycles mid-traffic -> all outputs 0, state IDLE.
- ADD a=4'hF, b=4'h1 -> result=0, carry=1, zero=1, overflow=0, done pulse 1 cycle after accept.
- ADD a=4'h7, b=4'h1 -> result=4'h8, overflow=1, negative=1, carry=0.
- SUB a=4'h3, b=4'h5 -> result=4'hE, carry=1, negative=1.
- SLTU 3,5 -> result=1.
- MUL a=4'hF, b=4'hF:
  - result_hi=4'hE, result=4'h1, carry=1.
  - busy high for exactly 4 cycles; done after edge N+4.
  - start pulsed with a=1, b=1 during busy is ignored.
  - Back-to-back start at done is accepted.
- MUL a=4'h6, b=4'h3 with rst asserted 2 cycles after accept:
  - No done pulse; outputs reset.
  - A subsequent MUL of 4'h2 by 4'h3 gives result=4'h6, result_hi=0.

Source files
------------

// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and opcode in, registered result and flags out.
interface seq_alu_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       operation;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             negative;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, operation,
    input  result, result_hi, carry, overflow, zero, negative, busy, done
  );

  modport slave (
    input  start, a, b, operation,
    output result, result_hi, carry, overflow, zero, negative, busy, done
  );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU with start/busy/done handshake; single-cycle logic/arith ops and a
// WIDTH-cycle shift-add unsigned multiplier producing a 2*WIDTH-bit product.
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  seq_alu_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic {S_IDLE, S_MULT} state_e;

  state_e                 state_q, state_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic [WIDTH-1:0]       result_hi_q, result_hi_d;
  logic                   carry_q, carry_d;
  logic                   overflow_q, overflow_d;
  logic                   zero_q, zero_d;
  logic                   negative_q, negative_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   accept;
  logic                   mul_last;
  logic [WIDTH:0]         sum;
  logic [WIDTH-1:0]       diff;
  logic                   lt;
  logic [WIDTH-1:0]       alu_res;
  logic                   alu_c;
  logic                   alu_v;
  logic [2*WIDTH-1:0]     prod;

  assign accept   = (state_q == S_IDLE) && bus.start;
  assign mul_last = (state_q == S_MULT) && (cnt_q == CW'(WIDTH-1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && bus.operation == OP_MUL) state_d = S_MULT;
      S_MULT: if (mul_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle datapath works straight off the inputs sampled at the accept edge
  always_comb begin
    sum     = {1'b0, bus.a} + {1'b0, bus.b};
    diff    = bus.a - bus.b;
    lt      = bus.a < bus.b;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.operation)
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = lt;
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SHL: begin
        alu_res = {bus.a[WIDTH-2:0], 1'b0};
        alu_c   = bus.a[WIDTH-1];
      end
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, lt};
      default: alu_res = '0;
    endcase
  end

  // Output / datapath next-state
  always_comb begin
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    done_d      = 1'b0;
    busy_d      = (state_d == S_MULT);
    prod        = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.operation == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, bus.a};
            mplier_d = bus.b;
            cnt_d    = '0;
          end else begin
            result_d    = alu_res;
            result_hi_d = '0;
            carry_d     = alu_c;
            overflow_d  = alu_v;
            zero_d      = (alu_res == '0);
            negative_d  = alu_res[WIDTH-1];
            done_d      = 1'b1;
          end
        end
      end
      S_MULT: begin
        acc_d    = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Visible outputs only move on the final bit, so they hold during MULT
        if (mul_last) begin
          result_d    = prod[WIDTH-1:0];
          result_hi_d = prod[2*WIDTH-1:WIDTH];
          carry_d     = |prod[2*WIDTH-1:WIDTH];
          overflow_d  = 1'b0;
          zero_d      = (prod == '0);
          negative_d  = prod[WIDTH-1];
          done_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed plus random checks of seq_alu against an arithmetic reference model.
module tb_seq_alu;
  localparam int W    = 4;
  localparam int M    = 1 << W;
  localparam int HALF = M / 2;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  int exp_r, exp_hi, exp_c, exp_v, exp_z, exp_n;

  seq_alu_if #(.WIDTH(W)) bus();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    n_chk++;
    assert (obs === 32'(expv)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= HALF) ? x - M : x;
  endfunction

  // Reference: plain integer arithmetic on the opcode definitions
  task automatic model(input int op, input int a, input int b);
    int s;
    exp_hi = 0; exp_c = 0; exp_v = 0;
    case (op)
      0: exp_r = a & b;
      1: exp_r = a | b;
      2: begin
        exp_r = (a + b) % M;
        exp_c = (a + b >= M);
        s     = sgn(a) + sgn(b);
        exp_v = (s >= HALF || s < -HALF);
      end
      3: begin
        exp_r = (a - b + M) % M;
        exp_c = (a < b);
        s     = sgn(a) - sgn(b);
        exp_v = (s >= HALF || s < -HALF);
      end
      4: exp_r = a ^ b;
      5: begin
        exp_r = (a * 2) % M;
        exp_c = (a >= HALF);
      end
      6: exp_r = (a < b) ? 1 : 0;
      default: begin
        exp_r  = (a * b) % M;
        exp_hi = (a * b) / M;
        exp_c  = (exp_hi != 0);
      end
    endcase
    exp_z = (exp_r == 0 && exp_hi == 0);
    exp_n = (exp_r >= HALF);
  endtask

  task automatic chk_out(input string tag, input int busy_e, input int done_e);
    chk({tag, ".result"},    32'(bus.result),    exp_r);
    chk({tag, ".result_hi"}, 32'(bus.result_hi), exp_hi);
    chk({tag, ".carry"},     32'(bus.carry),     exp_c);
    chk({tag, ".overflow"},  32'(bus.overflow),  exp_v);
    chk({tag, ".zero"},      32'(bus.zero),      exp_z);
    chk({tag, ".negative"},  32'(bus.negative),  exp_n);
    chk({tag, ".busy"},      32'(bus.busy),      busy_e);
    chk({tag, ".done"},      32'(bus.done),      done_e);
  endtask

  task automatic drive(input int op, input int a, input int b, input logic st);
    bus.operation = 3'(op);
    bus.a         = W'(a);
    bus.b         = W'(b);
    bus.start     = st;
  endtask

  // One complete operation: accept, wait out MUL while checking outputs hold, check, check done drops
  task automatic run_op(input string tag, input int op, input int a, input int b);
    @(negedge clk); drive(op, a, b, 1'b1);
    @(posedge clk); #1; drive($urandom_range(0, 7), $urandom_range(0, M-1), $urandom_range(0, M-1), 1'b0);
    if (op == 7) begin
      for (int i = 0; i < W; i++) begin
        chk_out({tag, ".hold"}, 1, 0);
        @(posedge clk); #1;
      end
    end
    model(op, a, b);
    chk_out(tag, 0, 1);
    @(posedge clk); #1;
    chk_out({tag, ".after"}, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 1'b0);
    exp_r = 0; exp_hi = 0; exp_c = 0; exp_v = 0; exp_z = 0; exp_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0);
    @(negedge clk); rst = 1'b0;

    run_op("add_f_1",  2, 15, 1);
    run_op("add_7_1",  2, 7, 1);
    run_op("sub_3_5",  3, 3, 5);
    run_op("sltu_3_5", 6, 3, 5);

    // MUL F*F with an ignored start during busy, then a back-to-back ADD at done
    @(negedge clk); drive(7, 15, 15, 1'b1);
    @(posedge clk); #1; bus.start = 1'b0;
    chk_out("mulff.b0", 1, 0);
    @(negedge clk); drive(2, 1, 1, 1'b1);
    @(posedge clk); #1; bus.start = 1'b0;
    chk_out("mulff.b1", 1, 0);
    @(posedge clk); #1;
    chk_out("mulff.b2", 1, 0);
    @(negedge clk); drive(2, 2, 3, 1'b1);
    @(posedge clk); #1;
    chk_out("mulff.b3", 1, 0);
    @(posedge clk); #1;
    model(7, 15, 15);
    chk_out("mulff.done", 0, 1);
    @(posedge clk); #1; bus.start = 1'b0;
    model(2, 2, 3);
    chk_out("b2b_add", 0, 1);
    @(posedge clk); #1;
    chk_out("b2b_add.after", 0, 0);

    // Reset two cycles into a MUL: aborts with no done
    @(negedge clk); drive(7, 6, 3, 1'b1);
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_r = 0; exp_hi = 0; exp_c = 0; exp_v = 0; exp_z = 0; exp_n = 0;
    chk_out("mulrst", 0, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("mulrst.quiet", 0, 0);
    run_op("mul_2_3", 7, 2, 3);

    for (int k = 0; k < 40; k++)
      run_op($sformatf("rnd%0d", k), $urandom_range(0, 7), $urandom_range(0, M-1), $urandom_range(0, M-1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
